// File: rtl/uart_tx_responder_if.sv
// ---------------------------------------------------------------------------
// uart_tx_responder_if
//
// Register bus between the system bridge and the UART transmitter. The
// bridge has already decoded the 0x7F30..0x7F3F window, so WE is only high
// on a hit. Dout is combinational from Addr; IRQ is a level request.
//
// Signals:
//   Addr  [31:0]  byte address (only [3:2] used by the responder)
//   WE            write strobe, gated by bridge hit and byte enables
//   Din   [31:0]  write data
//   Dout  [31:0]  read data
//   IRQ           level interrupt request
//
// Modports:
//   master  bridge / CPU side
//   slave   UART responder side
// ---------------------------------------------------------------------------
interface uart_tx_responder_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout,
        output IRQ
    );
endinterface

// File: rtl/uart_tx_responder.sv
// ---------------------------------------------------------------------------
// uart_tx_responder
//
// Memory-mapped 8N1 UART transmitter. The CPU pushes bytes into a small TX
// FIFO; the FSM pops them and serialises them LSB first on txd at a
// programmable divisor. A registered level IRQ signals "FIFO drained and
// line idle".
//
// Register map (Addr[3:2]):
//   0 DATA     write pushes Din[7:0]; reads 0
//   1 STATUS   RO: [0] busy, [1] full, [2] empty, [3] overflow (sticky),
//              [8:4] count
//   2 CTRL     RW [1:0]: bit0 EN, bit1 IE; any write clears overflow
//   3 DIVISOR  RW [15:0]: cycles per bit, 0 behaves as 1
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset (0 = reset)
//   bus     register bus (slave modport): Addr, WE, Din, Dout, IRQ
//   txd     serial output, idle high
//
// Parameters:
//   FIFO_DEPTH  TX FIFO entries, power of 2 in 2..16
//   DIV_RESET   DIVISOR value after reset
// ---------------------------------------------------------------------------
module uart_tx_responder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_responder_if.slave  bus,
    output logic                txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Programmer-visible registers
    logic          ctrl_en;
    logic          ctrl_ie;
    logic [15:0]   divisor;
    logic          overflow;

    // FIFO storage and bookkeeping
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Transmit engine
    state_t        state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          irq_q;

    // Decode and derived conditions
    logic [1:0]    reg_sel;
    logic          wr_data;
    logic          wr_ctrl;
    logic          wr_div;
    logic          empty;
    logic          full;
    logic          busy;
    logic          bit_end;
    logic          pop;
    logic          push;
    logic [15:0]   reload;
    logic [7:0]    head;
    logic [31:0]   rd_data;
    logic          unused_bits;

    assign reg_sel = bus.Addr[3:2];
    assign wr_data = bus.WE && (reg_sel == 2'd0);
    assign wr_ctrl = bus.WE && (reg_sel == 2'd2);
    assign wr_div  = bus.WE && (reg_sel == 2'd3);

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign busy    = (state != IDLE);
    assign bit_end = (baud_cnt == 16'd0);
    assign head    = fifo_mem[rd_ptr];

    // A divisor of 0 is treated as 1, so both give a reload value of 0.
    assign reload  = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);

    // The FIFO is popped either when leaving IDLE or at the end of STOP, so
    // consecutive frames run without an idle gap while EN stays set.
    assign pop  = ctrl_en && !empty &&
                  ((state == IDLE) || ((state == STOP) && bit_end));

    // A push into a full FIFO still fits if the head leaves on this edge.
    assign push = wr_data && (!full || pop);

    assign unused_bits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din[31:16]};

    // Control registers. Writes to CTRL double as the overflow acknowledge;
    // a refused push sets the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en  <= 1'b0;
            ctrl_ie  <= 1'b0;
            divisor  <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en  <= bus.Din[0];
                ctrl_ie  <= bus.Din[1];
                overflow <= 1'b0;
            end else if (wr_data && !push) begin
                overflow <= 1'b1;
            end
            if (wr_div) begin
                divisor <= bus.Din[15:0];
            end
        end
    end

    // FIFO data array. It needs no reset: the pointers and count decide
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.Din[7:0];
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM. txd is a register that is set together with each state
    // change, so the line level always matches the bit being sent. The baud
    // counter is reloaded from the live DIVISOR at every bit boundary, so a
    // new divisor applies from the next bit without stretching this one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            txd       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift_reg <= head;
                        baud_cnt  <= reload;
                        state     <= START;
                        txd       <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= reload;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        txd      <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= reload;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            txd       <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_reg <= head;
                            baud_cnt  <= reload;
                            state     <= START;
                            txd       <= 1'b0;
                        end else begin
                            baud_cnt <= 16'd0;
                            state    <= IDLE;
                            txd      <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    // Registered interrupt: follows (IE & empty & idle) one cycle late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_ie && empty && !busy;
        end
    end

    assign bus.IRQ = irq_q;

    // Read mux; reads have no side effects.
    always_comb begin
        rd_data = 32'h0;
        case (reg_sel)
            2'd1: begin
                rd_data[0]   = busy;
                rd_data[1]   = full;
                rd_data[2]   = empty;
                rd_data[3]   = overflow;
                rd_data[8:4] = 5'(count);
            end
            2'd2: begin
                rd_data[0] = ctrl_en;
                rd_data[1] = ctrl_ie;
            end
            2'd3: begin
                rd_data[15:0] = divisor;
            end
            default: begin
                rd_data = 32'h0;
            end
        endcase
    end

    assign bus.Dout = rd_data;

endmodule

// File: tb/tb_uart_tx_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_responder
//
// Self-checking bench for uart_tx_responder. Expected line waveforms are
// built per frame from the byte value and divisor (bit k of the frame lasts
// D cycles: start 0, data LSB first, stop 1); the FIFO is modelled as a
// queue with a sticky overflow flag, and STATUS is derived arithmetically
// from that model.
// ---------------------------------------------------------------------------
module tb_uart_tx_responder;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic txd;

    uart_tx_responder_if bus_if ();

    uart_tx_responder #(
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (16'd434)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit          exp_wave [$];
    bit          cap_txd  [$];
    bit          cap_busy [$];
    bit          cap_irq  [$];
    byte unsigned model_q [$];
    bit          model_ovf;

    // ---------------- helpers (stimulus and modelling only) ----------------

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.Addr = a;
        bus_if.Din  = d;
        bus_if.WE   = 1'b1;
        @(negedge clk);
        bus_if.WE   = 1'b0;
        bus_if.Addr = 32'h4;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_if.Addr = a;
        #1;
        d = bus_if.Dout;
    endtask

    task automatic model_push(input byte unsigned b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    function automatic logic [31:0] status_model(input int cnt, input bit ovf, input bit bsy);
        return 32'(cnt * 16 + (ovf ? 8 : 0) + (cnt == 0 ? 4 : 0) +
                   (cnt == DEPTH ? 2 : 0) + (bsy ? 1 : 0));
    endfunction

    task automatic add_frame(input byte unsigned b, input int d);
        for (int i = 0; i < 10; i++) begin
            bit v;
            if (i == 0) v = 1'b0;
            else if (i == 9) v = 1'b1;
            else v = ((int'(b) >> (i - 1)) & 1) != 0;
            repeat (d) exp_wave.push_back(v);
        end
    endtask

    // Waits (bounded) for the first low txd sample, then records n cycles of
    // txd, STATUS.busy and IRQ. Optionally drives one register write at
    // capture index wr_at.
    task automatic capture(input int max_wait, input int n, input int wr_at,
                           input logic [31:0] wr_addr, input logic [31:0] wr_val,
                           output bit found);
        cap_txd.delete();
        cap_busy.delete();
        cap_irq.delete();
        found = 1'b0;
        bus_if.Addr = 32'h4;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            for (int k = 0; k < n; k++) begin
                if (k > 0) @(negedge clk);
                cap_txd.push_back(txd);
                cap_busy.push_back(bus_if.Dout[0]);
                cap_irq.push_back(bus_if.IRQ);
                if (k == wr_at) begin
                    bus_if.Addr = wr_addr;
                    bus_if.Din  = wr_val;
                    bus_if.WE   = 1'b1;
                end else if (wr_at >= 0 && k == wr_at + 1) begin
                    bus_if.WE   = 1'b0;
                    bus_if.Addr = 32'h4;
                end
            end
        end
    endtask

    // ------------------------------- tests ---------------------------------

    task automatic test_reset();
        logic [31:0] rd;
        reset       = 1'b0;
        bus_if.Addr = 32'h0;
        bus_if.Din  = 32'h0;
        bus_if.WE   = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        n_checks++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_txd: got %b expected 1", txd);
        end
        n_checks++;
        if (bus_if.IRQ !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_irq: got %b expected 0", bus_if.IRQ);
        end
        bus_read(32'h4, rd);
        n_checks++;
        if (rd !== status_model(0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got %h expected %h", rd, status_model(0, 1'b0, 1'b0));
        end
        bus_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h0000_01B2) begin
            n_fail++;
            $display("[TB] FAIL reset_divisor: got %h expected 000001b2", rd);
        end
        bus_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_registers();
        logic [31:0] rd;
        bus_write(32'h4, 32'hFFFF_FFFF);
        bus_read(32'h4, rd);
        n_checks++;
        if (rd !== status_model(0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL status_ro: got %h expected %h", rd, status_model(0, 1'b0, 1'b0));
        end
        bus_write(32'hC, 32'hABCD_1234);
        bus_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'h0000_1234) begin
            n_fail++;
            $display("[TB] FAIL divisor_rw: got %h expected 00001234", rd);
        end
        bus_write(32'h8, 32'hFFFF_FFFE);
        bus_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0000_0002) begin
            n_fail++;
            $display("[TB] FAIL ctrl_rw: got %h expected 00000002", rd);
        end
        bus_write(32'h8, 32'h0);
        bus_write(32'h0, 32'h77);
        model_push(8'h77);
        bus_read(32'h0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL data_read_zero: got %h expected 00000000", rd);
        end
        bus_read(32'h4, rd);
        n_checks++;
        if (rd !== status_model(model_q.size(), model_ovf, 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL status_one_entry: got %h expected %h", rd,
                     status_model(model_q.size(), model_ovf, 1'b0));
        end
        // Drain the pending byte quickly so later tests start from empty.
        bus_write(32'hC, 32'h1);
        bus_write(32'h8, 32'h1);
        repeat (20) @(negedge clk);
        bus_write(32'h8, 32'h0);
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic test_single_frame();
        bit found;
        int bad_txd;
        int bad_busy;
        logic [31:0] rd;
        bus_write(32'hC, 32'd4);
        bus_write(32'h8, 32'h1);
        bus_write(32'h0, 32'h55);
        exp_wave.delete();
        add_frame(8'h55, 4);
        capture(20, 40, -1, 32'h0, 32'h0, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL frame55_start: got no start bit expected start within 20 cycles");
        end
        bad_txd  = 0;
        bad_busy = 0;
        for (int k = 0; k < exp_wave.size(); k++) begin
            if (k >= cap_txd.size() || cap_txd[k] !== exp_wave[k]) bad_txd++;
            if (k >= cap_busy.size() || cap_busy[k] !== 1'b1) bad_busy++;
        end
        n_checks++;
        if (bad_txd !== 0) begin
            n_fail++;
            $display("[TB] FAIL frame55_txd: got %0d wrong cycles expected 0", bad_txd);
        end
        n_checks++;
        if (bad_busy !== 0) begin
            n_fail++;
            $display("[TB] FAIL frame55_busy: got %0d cycles not busy expected 0", bad_busy);
        end
        @(negedge clk);
        bus_read(32'h4, rd);
        n_checks++;
        if (rd !== status_model(0, 1'b0, 1'b0) || txd !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL frame55_after: got status %h txd %b expected %h txd 1",
                     rd, txd, status_model(0, 1'b0, 1'b0));
        end
        bus_write(32'h8, 32'h0);
    endtask

    task automatic test_back_to_back();
        bit found;
        int bad;
        logic [31:0] rd;
        bus_write(32'hC, 32'd2);
        bus_write(32'h8, 32'h0);
        model_ovf = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus_write(32'h0, 32'(i));
            model_push(8'(i));
        end
        bus_read(32'h4, rd);
        n_checks++;
        if (rd !== status_model(model_q.size(), model_ovf, 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL overflow_status: got %h expected %h", rd,
                     status_model(model_q.size(), model_ovf, 1'b0));
        end
        bus_write(32'h8, 32'h1);
        model_ovf = 1'b0;
        bus_read(32'h4, rd);
        n_checks++;
        if (rd[3] !== model_ovf) begin
            n_fail++;
            $display("[TB] FAIL overflow_clear: got %b expected %b", rd[3], model_ovf);
        end
        exp_wave.delete();
        foreach (model_q[i]) add_frame(model_q[i], 2);
        capture(5, exp_wave.size(), -1, 32'h0, 32'h0, found);
        model_q.delete();
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL b2b_start: got no start bit expected start within 5 cycles");
        end
        bad = 0;
        for (int k = 0; k < exp_wave.size(); k++)
            if (k >= cap_txd.size() || cap_txd[k] !== exp_wave[k]) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_txd: got %0d wrong cycles expected 0", bad);
        end
        @(negedge clk);
        bus_read(32'h4, rd);
        n_checks++;
        if (rd !== status_model(0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL b2b_drained: got %h expected %h", rd, status_model(0, 1'b0, 1'b0));
        end
        bus_write(32'h8, 32'h0);
    endtask

    task automatic test_irq();
        bit found;
        int bad;
        bus_write(32'hC, 32'd1);
        bus_write(32'h8, 32'h3);
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_if.IRQ !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_idle: got %b expected 1", bus_if.IRQ);
        end
        bus_write(32'h0, 32'hA5);
        exp_wave.delete();
        add_frame(8'hA5, 1);
        capture(5, 10, -1, 32'h0, 32'h0, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL irq_frame_start: got no start bit expected start within 5 cycles");
        end
        bad = 0;
        for (int k = 0; k < 10; k++)
            if (k >= cap_irq.size() || cap_irq[k] !== 1'b0 || cap_txd[k] !== exp_wave[k]) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL irq_during_frame: got %0d bad cycles expected 0", bad);
        end
        @(negedge clk);
        n_checks++;
        if (bus_if.IRQ !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_first_idle: got %b expected 0", bus_if.IRQ);
        end
        @(negedge clk);
        n_checks++;
        if (bus_if.IRQ !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_rise: got %b expected 1", bus_if.IRQ);
        end
        bus_write(32'h8, 32'h1);
        n_checks++;
        if (bus_if.IRQ !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_hold: got %b expected 1", bus_if.IRQ);
        end
        @(negedge clk);
        n_checks++;
        if (bus_if.IRQ !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_fall: got %b expected 0", bus_if.IRQ);
        end
        bus_write(32'h8, 32'h0);
    endtask

    task automatic test_divisor_change();
        bit found;
        int bad;
        byte unsigned b;
        logic [31:0] rd;
        b = 8'($urandom);
        bus_write(32'hC, 32'd8);
        bus_write(32'h8, 32'h1);
        bus_write(32'h0, 32'(b));
        // Start and data bits 0..2 at 8 cycles, then bits 3..7 and stop at 2.
        exp_wave.delete();
        repeat (8) exp_wave.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            repeat (i < 3 ? 8 : 2) exp_wave.push_back(((int'(b) >> i) & 1) != 0);
        repeat (2) exp_wave.push_back(1'b1);
        capture(20, exp_wave.size(), 26, 32'hC, 32'd2, found);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL divchg_start: got no start bit expected start within 20 cycles");
        end
        bad = 0;
        for (int k = 0; k < exp_wave.size(); k++)
            if (k >= cap_txd.size() || cap_txd[k] !== exp_wave[k]) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL divchg_txd: byte %h got %0d wrong cycles expected 0", b, bad);
        end
        bus_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("[TB] FAIL divchg_readback: got %h expected 00000002", rd);
        end
        bus_write(32'h8, 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        bit found;
        int bad;
        int d;
        int deff;
        int n;
        byte unsigned b;
        logic [31:0] rd;
        for (int it = 0; it < 5; it++) begin
            d    = $urandom_range(0, 5);
            deff = (d == 0) ? 1 : d;
            n    = $urandom_range(1, DEPTH);
            bus_write(32'hC, 32'(d));
            bus_write(32'h8, 32'h0);
            model_ovf = 1'b0;
            model_q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                bus_write(32'h0, 32'(b));
                model_push(b);
            end
            bus_read(32'h4, rd);
            n_checks++;
            if (rd !== status_model(model_q.size(), model_ovf, 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_status: got %h expected %h", it, rd,
                         status_model(model_q.size(), model_ovf, 1'b0));
            end
            exp_wave.delete();
            foreach (model_q[i]) add_frame(model_q[i], deff);
            bus_write(32'h8, 32'h1);
            capture(5, exp_wave.size(), -1, 32'h0, 32'h0, found);
            model_q.delete();
            bad = found ? 0 : 1;
            for (int k = 0; k < exp_wave.size(); k++)
                if (k >= cap_txd.size() || cap_txd[k] !== exp_wave[k]) bad++;
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_txd: div %0d bytes %0d got %0d bad cycles expected 0",
                         it, d, n, bad);
            end
            @(negedge clk);
            bus_read(32'h4, rd);
            n_checks++;
            if (rd !== status_model(0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_drained: got %h expected %h", it, rd,
                         status_model(0, 1'b0, 1'b0));
            end
            bus_write(32'h8, 32'h0);
        end
    endtask

    task automatic test_reset_midframe();
        int lows;
        logic [31:0] rd;
        bus_write(32'hC, 32'd8);
        bus_write(32'h8, 32'h1);
        bus_write(32'h0, 32'h3C);
        bus_write(32'h0, 32'hC3);
        bus_write(32'h0, 32'h99);
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_txd: got %b expected 1", txd);
        end
        bus_read(32'h4, rd);
        n_checks++;
        if (rd !== status_model(0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL midreset_status: got %h expected %h", rd, status_model(0, 1'b0, 1'b0));
        end
        @(negedge clk);
        reset = 1'b1;
        lows = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_checks++;
        if (lows !== 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_residual: got %0d low cycles expected 0", lows);
        end
        bus_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_ctrl: got %h expected 00000000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_single_frame();
        test_back_to_back();
        test_irq();
        test_divisor_change();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
